// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - direct-mapped one-word-per-line instruction cache
//
// Serves fetch hits in one cycle from registered storage. On a miss it issues
// one word request to the memory controller, installs the returned word and
// forwards it to fetch if the same PC is still being requested.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                global run enable (0 = pause)
//   clear_en              invalidate all lines (fence.i / flush)
//   fetch_en, fetch_addr  fetch request (level) and PC
//   fetch_ready           one-cycle pulse, fetch_data valid for fetch_addr
//   fetch_data            instruction word
//   mem_query_en          block request to memory controller (level)
//   mem_addr              word-aligned block address
//   mem_block_en          memory controller block-done pulse
//   mem_block_data        fetched word
module icache_controller #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_en,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic [31:0]           fetch_data,
  output logic                  mem_query_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_block_en,
  input  logic [31:0]           mem_block_data
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]            state;
  logic [LINES-1:0]      valid;
  logic                  discard;
  logic [ADDR_WIDTH-1:0] miss_addr;

  logic [31:0]           data_mem [LINES];
  logic [TAG_BITS-1:0]   tag_mem  [LINES];

  logic [INDEX_BITS-1:0] fetch_index;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  hit;
  logic                  refill_done;
  logic                  install;
  logic                  same_word;

  assign fetch_index = fetch_addr[INDEX_BITS+1:2];
  assign fetch_tag   = fetch_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign miss_index  = miss_addr[INDEX_BITS+1:2];
  assign miss_tag    = miss_addr[ADDR_WIDTH-1:INDEX_BITS+2];

  assign hit         = valid[fetch_index] && (tag_mem[fetch_index] == fetch_tag);
  assign refill_done = rdy_in && (state == WAIT) && mem_block_en;
  // A clear requested during the refill (earlier or in this very cycle)
  // suppresses the install so stale code never lands after fence.i.
  assign install     = refill_done && !discard && !clear_en;
  assign same_word   = fetch_addr[ADDR_WIDTH-1:2] == miss_addr[ADDR_WIDTH-1:2];

  // Line payload carries no reset; its valid bit guards every use.
  always_ff @(posedge clk_in) begin
    if (install) begin
      data_mem[miss_index] <= mem_block_data;
      tag_mem[miss_index]  <= miss_tag;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      valid        <= '0;
      discard      <= 1'b0;
      miss_addr    <= '0;
      mem_query_en <= 1'b0;
      mem_addr     <= '0;
      fetch_ready  <= 1'b0;
      fetch_data   <= '0;
    end else if (!rdy_in) begin
      fetch_ready <= 1'b0;
    end else begin
      fetch_ready <= 1'b0;
      if (clear_en) begin
        valid <= '0;
      end
      case (state)
        IDLE: begin
          if (fetch_en && !clear_en) begin
            if (hit) begin
              fetch_ready <= 1'b1;
              fetch_data  <= data_mem[fetch_index];
            end else begin
              mem_query_en <= 1'b1;
              mem_addr     <= {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
              miss_addr    <= fetch_addr;
              state        <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_block_en) begin
            // The request cannot be cancelled, so the handshake always
            // completes here; discard only decides whether the word is kept.
            mem_query_en <= 1'b0;
            state        <= IDLE;
            discard      <= 1'b0;
            if (install) begin
              valid[miss_index] <= 1'b1;
              if (fetch_en && same_word) begin
                fetch_ready <= 1'b1;
                fetch_data  <= mem_block_data;
              end
            end
          end else if (clear_en) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
